cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Instruction-cycle controller and instruction register for the 8-bit RISC CPU; the stage directly upstream of the ALU.
//  Captures each instruction byte from the data bus, drives the opcode onto ALU alu_op and consumes ALU SKZ_cmp.
//  Runs a fixed 8-phase fetch/execute cycle; emits the bus, PC and accumulator strobes that move data through the ALU.
// PARAMETERS
//  DATA_W  8  instruction / data-bus width
//  OP_W    3  opcode field width, ir[DATA_W-1 -: OP_W]
//  ADDR_W  5  operand address field width, ir[ADDR_W-1:0]; must satisfy OP_W+ADDR_W == DATA_W
// PORTS
//  clk      in   1       rising-edge clock
//  rst_n    in   1       synchronous, active-low reset
//  data_in  in   DATA_W  memory read data; IR source
//  skz_cmp  in   1       ALU zero flag
//  alu_op   out  OP_W    IR opcode field -> ALU alu_op
//  ir_addr  out  ADDR_W  IR operand address field
//  phase    out  3       current phase, 0..7
//  sel      out  1       1 = address mux selects PC, 0 = selects ir_addr
//  rd       out  1       memory read enable
//  ld_ir    out  1       IR load window
//  inc_pc   out  1       PC increment
//  ld_pc    out  1       PC load from ir_addr
//  ld_ac    out  1       accumulator load from alu_out
//  data_e   out  1       accumulator drives data bus
//  wr       out  1       memory write
//  halt     out  1       CPU halted
// BEHAVIOUR
//  Opcodes: HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111. ALUOP = ADD|AND|XOR|LDA.
//  Reset (rst_n low at a clk edge): phase=0, IR=8'h00, halted=0.
//  Post-reset outputs are phase-0 decode: sel=1; all other strobes 0; halt=0; alu_op=000; ir_addr=0.
//  phase advances by +1 each clk and wraps 7->0; no stall input.
//  IR captures data_in on the clk edge that ends phase 3. alu_op and ir_addr are valid from phase 4 onward.
//  Strobes are a Moore decode of {phase, IR, halted}, with one exception: inc_pc in phase 6 uses skz_cmp combinationally.
//  Strobe decode per phase (signals not listed = 0):
//   ph0 INST_ADDR : sel
//   ph1 INST_FETCH: sel, rd
//   ph2 INST_LOAD : sel, rd, ld_ir
//   ph3 IDLE      : sel, rd, ld_ir
//   ph4 OP_ADDR   : inc_pc; halt=1 if HLT
//   ph5 OP_FETCH  : rd=ALUOP
//   ph6 ALU_OP    : rd=ALUOP; inc_pc=(SKZ & skz_cmp); ld_pc=JMP; data_e=STO
//   ph7 STORE     : rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; data_e=STO; wr=STO
//  HLT: on the edge ending ph4, halted<=1 and phase freezes at 4.
//   While halted: halt=1, every other strobe = 0 (including sel and inc_pc).
//   Only rst_n low exits halt; PC has been incremented exactly once.
//  wr is asserted only in ph7 and only together with data_e; it is never asserted in the same cycle as rd.
//  Reset mid-cycle overrides everything: the next cycle is phase 0 and no pending ld_ac/wr/ld_pc issues.
//  Width rule: all field slices are exact, no extension; phase is a 3-bit counter wrapping naturally.
// STRUCTURE
//  Package cpu_pkg: opcode localparams (OP_HLT..OP_JMP), phase encodings (PH_INST_ADDR..PH_STORE), DATA_W/OP_W/ADDR_W.
//  Top level holds the phase counter, halted flag and IR.
//  Sub-module seq_decode (combinational): {phase, opcode, halted, skz_cmp} -> strobe vector.
// TESTING
//  Reset: hold rst_n=0 for 2 clk, then release -> phase=0, sel=1, every other strobe 0, alu_op=000.
//  ADD: data_in=8'h4A during ph2-3 -> from ph4 alu_op=010, ir_addr=0A.
//   rd in ph1,2,3,5,6,7; ld_ir in ph2-3; inc_pc in ph4 only; ld_ac in ph7 only.
//  SKZ: data_in=8'h20. skz_cmp=1 -> inc_pc in ph4 and ph6. skz_cmp=0 -> inc_pc in ph4 only. No rd in ph5-7.
//  STO/JMP: 8'hC3 -> data_e in ph6-7, wr in ph7 only, no rd in ph5-7, ld_ac=0.
//   8'hE5 -> ld_pc in ph6-7, ir_addr=05.
//  HLT: data_in=8'h00 -> ph4 shows halt=1, inc_pc=1. Then phase stuck at 4, halt=1, all strobes 0 for 20 clk.
//   rst_n pulse -> phase=0, halt=0.
//  Reset mid-op: run STO, drive rst_n=0 during ph6 -> next cycle phase=0, IR=00, wr never asserted.
//   Sequencer resumes normally after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes, phase encodings and strobe bundle for the CPU sequencer
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int ADDR_W = 5;

  localparam logic [OP_W-1:0] OP_HLT = 3'b000;
  localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_LDA = 3'b101;
  localparam logic [OP_W-1:0] OP_STO = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic data_e;
    logic wr;
    logic halt;
  } strobe_t;

  // Opcodes that read an operand and write the accumulator.
  function automatic logic is_aluop(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - data-bus, ALU and strobe signals between the sequencer and the datapath
import cpu_pkg::*;

interface cpu_sequencer_if;
  logic [DATA_W-1:0] data_in;
  logic              skz_cmp;
  logic [OP_W-1:0]   alu_op;
  logic [ADDR_W-1:0] ir_addr;
  logic [2:0]        phase;
  logic              sel;
  logic              rd;
  logic              ld_ir;
  logic              inc_pc;
  logic              ld_pc;
  logic              ld_ac;
  logic              data_e;
  logic              wr;
  logic              halt;

  modport master (
    output data_in, skz_cmp,
    input  alu_op, ir_addr, phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt
  );

  modport slave (
    input  data_in, skz_cmp,
    output alu_op, ir_addr, phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt
  );
endinterface

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational strobe decode from phase, opcode, halted flag and ALU zero flag
module seq_decode
  import cpu_pkg::*;
(
  input  phase_t          i_phase,
  input  logic [OP_W-1:0] i_opcode,
  input  logic            i_halted,
  input  logic            i_skz_cmp,
  output strobe_t         o_strobe
);

  logic w_alu;
  logic w_sto;
  logic w_jmp;

  assign w_alu = is_aluop(i_opcode);
  assign w_sto = (i_opcode == OP_STO);
  assign w_jmp = (i_opcode == OP_JMP);

  always_comb begin
    o_strobe = '0;
    if (i_halted) begin
      o_strobe.halt = 1'b1;
    end else begin
      case (i_phase)
        PH_INST_ADDR: o_strobe.sel = 1'b1;
        PH_INST_FETCH: begin
          o_strobe.sel = 1'b1;
          o_strobe.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          o_strobe.sel   = 1'b1;
          o_strobe.rd    = 1'b1;
          o_strobe.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          o_strobe.inc_pc = 1'b1;
          o_strobe.halt   = (i_opcode == OP_HLT);
        end
        PH_OP_FETCH: o_strobe.rd = w_alu;
        // skz_cmp is the only input that reaches a strobe without a register.
        PH_ALU_OP: begin
          o_strobe.rd     = w_alu;
          o_strobe.inc_pc = (i_opcode == OP_SKZ) & i_skz_cmp;
          o_strobe.ld_pc  = w_jmp;
          o_strobe.data_e = w_sto;
        end
        PH_STORE: begin
          o_strobe.rd     = w_alu;
          o_strobe.ld_ac  = w_alu;
          o_strobe.ld_pc  = w_jmp;
          o_strobe.data_e = w_sto;
          o_strobe.wr     = w_sto;
        end
        default: o_strobe = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - 8-phase fetch/execute controller holding the phase counter, halted flag and IR
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.slave  bus
);

  phase_t            r_phase;
  phase_t            w_phase_nxt;
  logic              r_halted;
  logic              w_halted_nxt;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] w_ir_nxt;
  logic [OP_W-1:0]   w_opcode;
  strobe_t           w_strobe;

  assign w_opcode = r_ir[DATA_W-1 -: OP_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase  <= PH_INST_ADDR;
      r_halted <= 1'b0;
      r_ir     <= '0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
      r_ir     <= w_ir_nxt;
    end
  end

  always_comb begin
    w_phase_nxt  = phase_t'(r_phase + 3'd1);
    w_halted_nxt = r_halted;
    w_ir_nxt     = r_ir;
    if (r_halted) begin
      w_phase_nxt = r_phase;
    end else if (r_phase == PH_IDLE) begin
      w_ir_nxt = bus.data_in;
    end else if ((r_phase == PH_OP_ADDR) && (w_opcode == OP_HLT)) begin
      // Freeze at phase 4 so the single PC increment of HLT is never repeated.
      w_halted_nxt = 1'b1;
      w_phase_nxt  = r_phase;
    end
  end

  seq_decode u_decode (
    .i_phase   (r_phase),
    .i_opcode  (w_opcode),
    .i_halted  (r_halted),
    .i_skz_cmp (bus.skz_cmp),
    .o_strobe  (w_strobe)
  );

  assign bus.alu_op  = w_opcode;
  assign bus.ir_addr = r_ir[ADDR_W-1:0];
  assign bus.phase   = r_phase;
  assign bus.sel     = w_strobe.sel;
  assign bus.rd      = w_strobe.rd;
  assign bus.ld_ir   = w_strobe.ld_ir;
  assign bus.inc_pc  = w_strobe.inc_pc;
  assign bus.ld_pc   = w_strobe.ld_pc;
  assign bus.ld_ac   = w_strobe.ld_ac;
  assign bus.data_e  = w_strobe.data_e;
  assign bus.wr      = w_strobe.wr;
  assign bus.halt    = w_strobe.halt;

endmodule
